// File: rtl/alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// alu_issue_decoder
//
// One registered decode/issue stage between fetch and execute. Each accepted
// 32-bit MIPS instruction is turned into an ALU bundle: function code, operand
// selects, register indices and extended immediate. After a branch or jump
// bundle (function code 111xxx) is taken by execute, issue is held off until
// execute pulses Resolve_in. Accepted bundles and illegal bundles are counted
// with saturating counters.
//
// Ports
//   Clk_in, Rst_n_in     clock (rising edge), synchronous active-low reset
//   Instr_in, Valid_in   instruction from fetch and its valid
//   Ready_out            stage accepts Instr_in this cycle
//   Func_out             ALU function code
//   Rs_out, Rt_out       source register indices (raw instruction fields)
//   Rd_out               destination register (31 for JAL)
//   Imm_out              extended immediate or jump target {6'b0, instr[25:0]}
//   UseImm_out           ALU B operand is Imm_out
//   ZeroA_out            ALU A operand forced to zero (LUI)
//   RegWrite_out         bundle writes Rd_out
//   Illegal_out          unsupported opcode/funct, travels with the bundle
//   Valid_out, Ready_in  bundle handshake towards execute
//   Resolve_in           one-cycle pulse: outstanding branch/jump resolved
//   Flush_in             kill bundle in stage and the incoming instruction
//   Issued_cnt_out       bundles taken by execute (saturating)
//   Illegal_cnt_out      illegal bundles taken by execute (saturating)
// ---------------------------------------------------------------------------
module alu_issue_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             Clk_in,
    input  logic             Rst_n_in,
    input  logic [31:0]      Instr_in,
    input  logic             Valid_in,
    output logic             Ready_out,
    output logic [5:0]       Func_out,
    output logic [4:0]       Rs_out,
    output logic [4:0]       Rt_out,
    output logic [4:0]       Rd_out,
    output logic [31:0]      Imm_out,
    output logic             UseImm_out,
    output logic             ZeroA_out,
    output logic             RegWrite_out,
    output logic             Valid_out,
    input  logic             Ready_in,
    input  logic             Resolve_in,
    input  logic             Flush_in,
    output logic             Illegal_out,
    output logic [CNT_W-1:0] Issued_cnt_out,
    output logic [CNT_W-1:0] Illegal_cnt_out
);

    // ALU function codes produced by this stage
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_BLTZ = 6'b111000;
    localparam logic [5:0] FN_BGEZ = 6'b111001;
    localparam logic [5:0] FN_J    = 6'b111010;
    localparam logic [5:0] FN_JR   = 6'b111011;

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_t;

    // -----------------------------------------------------------------------
    // Instruction fields
    // -----------------------------------------------------------------------
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_field;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign opcode   = Instr_in[31:26];
    assign funct    = Instr_in[5:0];
    assign rs_field = Instr_in[25:21];
    assign rt_field = Instr_in[20:16];
    assign rd_field = Instr_in[15:11];
    assign imm_sext = {{16{Instr_in[15]}}, Instr_in[15:0]};
    assign imm_zext = {16'h0000, Instr_in[15:0]};

    // -----------------------------------------------------------------------
    // Combinational decode of Instr_in
    // -----------------------------------------------------------------------
    logic [5:0]  dec_func;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        dec_use_imm;
    logic        dec_zero_a;
    logic        dec_reg_write;
    logic        dec_illegal;

    always_comb begin
        // NOTE: every output of a combinational block gets a default up front,
        // so no path through the case statements can leave it unassigned and
        // infer a latch.
        dec_func      = 6'b000000;
        dec_rd        = 5'd0;
        dec_imm       = 32'h0000_0000;
        dec_use_imm   = 1'b0;
        dec_zero_a    = 1'b0;
        dec_reg_write = 1'b0;
        dec_illegal   = 1'b0;

        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011: begin
                        // R-type ALU ops: the funct field already is the ALU code
                        dec_func      = funct;
                        dec_reg_write = 1'b1;
                        dec_rd        = rd_field;
                    end
                    6'b001000: begin
                        dec_func = FN_JR;
                    end
                    6'b001001: begin
                        dec_func      = FN_JR;
                        dec_reg_write = 1'b1;
                        dec_rd        = rd_field;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end

            6'b000001: begin
                // REGIMM: only BLTZ (rt=0) and BGEZ (rt=1) are supported
                dec_imm = imm_sext;
                if (rt_field == 5'd0) begin
                    dec_func = FN_BLTZ;
                end else if (rt_field == 5'd1) begin
                    dec_func = FN_BGEZ;
                end else begin
                    dec_imm     = 32'h0000_0000;
                    dec_illegal = 1'b1;
                end
            end

            6'b000010, 6'b000011: begin
                dec_func = FN_J;
                dec_imm  = {6'b000000, Instr_in[25:0]};
                if (opcode[0]) begin
                    // JAL links into $31
                    dec_reg_write = 1'b1;
                    dec_rd        = 5'd31;
                end
            end

            6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                // BEQ/BNE/BLEZ/BGTZ map onto 1111xx in opcode order
                dec_func = {4'b1111, opcode[1:0]};
                dec_imm  = imm_sext;
            end

            6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
                case (opcode[1:0])
                    2'b00:   dec_func = FN_ADD;
                    2'b01:   dec_func = FN_ADDU;
                    2'b10:   dec_func = FN_SLT;
                    default: dec_func = FN_SLTU;
                endcase
                dec_imm       = imm_sext;
                dec_use_imm   = 1'b1;
                dec_reg_write = 1'b1;
                dec_rd        = rt_field;
            end

            6'b001100, 6'b001101, 6'b001110: begin
                // ANDI/ORI/XORI map onto AND/OR/XOR (1001xx) with zero-extension
                dec_func      = {4'b1001, opcode[1:0]};
                dec_imm       = imm_zext;
                dec_use_imm   = 1'b1;
                dec_reg_write = 1'b1;
                dec_rd        = rt_field;
            end

            6'b001111: begin
                // LUI executes as 0 | (imm << 16)
                dec_func      = FN_OR;
                dec_imm       = {Instr_in[15:0], 16'h0000};
                dec_use_imm   = 1'b1;
                dec_zero_a    = 1'b1;
                dec_reg_write = 1'b1;
                dec_rd        = rt_field;
            end

            6'b100011, 6'b101011: begin
                // LW/SW: ALU computes base + offset; only LW writes back
                dec_func    = FN_ADDU;
                dec_imm     = imm_sext;
                dec_use_imm = 1'b1;
                if (!opcode[3]) begin
                    dec_reg_write = 1'b1;
                    dec_rd        = rt_field;
                end
            end

            default: dec_illegal = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Issue FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   valid_q;
    logic   ready_out;
    logic   accept;
    logic   xfer;
    logic [5:0] func_q;

    // Flush wins over both handshakes
    assign accept = Valid_in & ready_out & ~Flush_in;
    assign xfer   = valid_q & Ready_in & ~Flush_in;

    always_ff @(posedge Clk_in) begin
        // NOTE: clocked state is always updated with non-blocking assignments
        // so every flop samples the pre-edge values of the others.
        if (!Rst_n_in) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Flush_in) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // Resolve_in is ignored here; only a branch/jump leaving
                    // the stage starts the stall
                    if (xfer && (func_q[5:3] == 3'b111)) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (Resolve_in) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        ready_out = (state_q == ST_RUN) & (~valid_q | Ready_in);
    end

    // -----------------------------------------------------------------------
    // Bundle register and counters
    // -----------------------------------------------------------------------
    logic              valid_d;
    logic [5:0]        func_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       imm_q, imm_d;
    logic              use_imm_q, use_imm_d;
    logic              zero_a_q, zero_a_d;
    logic              reg_write_q, reg_write_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;
    logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        valid_d     = valid_q;
        func_d      = func_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        zero_a_d    = zero_a_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;

        if (Flush_in) begin
            valid_d = 1'b0;
        end else if (accept) begin
            // A new instruction may enter in the same cycle the old bundle leaves
            valid_d     = 1'b1;
            func_d      = dec_func;
            rs_d        = rs_field;
            rt_d        = rt_field;
            rd_d        = dec_rd;
            imm_d       = dec_imm;
            use_imm_d   = dec_use_imm;
            zero_a_d    = dec_zero_a;
            reg_write_d = dec_reg_write;
            illegal_d   = dec_illegal;
        end else if (xfer) begin
            valid_d = 1'b0;
        end

        issued_cnt_d  = issued_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (xfer && (issued_cnt_q != {CNT_W{1'b1}})) begin
            issued_cnt_d = issued_cnt_q + CNT_W'(1);
        end
        if (xfer && illegal_q && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk_in) begin
        if (!Rst_n_in) begin
            valid_q       <= 1'b0;
            func_q        <= 6'b000000;
            rs_q          <= 5'd0;
            rt_q          <= 5'd0;
            rd_q          <= 5'd0;
            imm_q         <= 32'h0000_0000;
            use_imm_q     <= 1'b0;
            zero_a_q      <= 1'b0;
            reg_write_q   <= 1'b0;
            illegal_q     <= 1'b0;
            issued_cnt_q  <= '0;
            illegal_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            func_q        <= func_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            use_imm_q     <= use_imm_d;
            zero_a_q      <= zero_a_d;
            reg_write_q   <= reg_write_d;
            illegal_q     <= illegal_d;
            issued_cnt_q  <= issued_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign Ready_out       = ready_out;
    assign Valid_out       = valid_q;
    assign Func_out        = func_q;
    assign Rs_out          = rs_q;
    assign Rt_out          = rt_q;
    assign Rd_out          = rd_q;
    assign Imm_out         = imm_q;
    assign UseImm_out      = use_imm_q;
    assign ZeroA_out       = zero_a_q;
    assign RegWrite_out    = reg_write_q;
    assign Illegal_out     = illegal_q;
    assign Issued_cnt_out  = issued_cnt_q;
    assign Illegal_cnt_out = illegal_cnt_q;

endmodule
